// File: rtl/buzzer_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_pattern_driver
//  Purpose  : Gates a square-wave tone into an on/off beep cadence for the
//             piezo, with a minimum beep count, operator silence and arm.
//  Revision : 1.0  initial release
// ============================================================================
module buzzer_pattern_driver #(
   parameter int TONE_HALF = 12500,
   parameter int BEEP_ON   = 10000000,
   parameter int BEEP_OFF  = 15000000,
   parameter int MIN_BEEPS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       alarm_in,
   input  logic       silence,
   output logic       buzzer_pwm,
   output logic       active,
   output logic       silenced,
   output logic [7:0] beep_count
);

   localparam int c_TONE_W   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
   localparam int c_ON_W     = (BEEP_ON   > 1) ? $clog2(BEEP_ON)   : 1;
   localparam int c_OFF_W    = (BEEP_OFF  > 1) ? $clog2(BEEP_OFF)  : 1;
   // One phase counter serves both ON and OFF, so size it for the longer one
   localparam int c_PHASE_W  = (c_ON_W > c_OFF_W) ? c_ON_W : c_OFF_W;

   localparam logic [c_TONE_W-1:0]  c_TONE_LAST = c_TONE_W'(TONE_HALF - 1);
   localparam logic [c_PHASE_W-1:0] c_ON_LAST   = c_PHASE_W'(BEEP_ON - 1);
   localparam logic [c_PHASE_W-1:0] c_OFF_LAST  = c_PHASE_W'(BEEP_OFF - 1);
   localparam logic [7:0]           c_MIN_BEEPS = 8'(MIN_BEEPS);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ON       = 2'd1,
      S_OFF      = 2'd2,
      S_SILENCED = 2'd3
   } state_t;

   state_t                 r_state;
   logic [c_TONE_W-1:0]    r_tone_cnt;
   logic [c_PHASE_W-1:0]   r_phase_cnt;
   logic                   r_pwm;
   logic                   r_active;
   logic                   r_silenced;
   logic [7:0]             r_beep_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_tone_cnt   <= '0;
         r_phase_cnt  <= '0;
         r_pwm        <= 1'b0;
         r_active     <= 1'b0;
         r_silenced   <= 1'b0;
         r_beep_count <= 8'd0;
      end else if (!enable) begin
         r_state    <= S_IDLE;
         r_pwm      <= 1'b0;
         r_active   <= 1'b0;
         r_silenced <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (alarm_in) begin
                  r_state      <= S_ON;
                  r_beep_count <= 8'd0;
                  r_phase_cnt  <= '0;
                  r_tone_cnt   <= '0;
                  r_pwm        <= 1'b1;
                  r_active     <= 1'b1;
               end
            end

            S_ON: begin
               if (silence) begin
                  r_state    <= S_SILENCED;
                  r_pwm      <= 1'b0;
                  r_active   <= 1'b0;
                  r_silenced <= 1'b1;
               end else if (r_phase_cnt == c_ON_LAST) begin
                  // Beep may end mid half-period; the tone simply stops here
                  r_state     <= S_OFF;
                  r_pwm       <= 1'b0;
                  r_phase_cnt <= '0;
                  if (r_beep_count != 8'hFF)
                     r_beep_count <= r_beep_count + 8'd1;
               end else begin
                  r_phase_cnt <= r_phase_cnt + c_PHASE_W'(1);
                  if (r_tone_cnt == c_TONE_LAST) begin
                     r_tone_cnt <= '0;
                     r_pwm      <= ~r_pwm;
                  end else begin
                     r_tone_cnt <= r_tone_cnt + c_TONE_W'(1);
                  end
               end
            end

            S_OFF: begin
               if (silence) begin
                  r_state    <= S_SILENCED;
                  r_pwm      <= 1'b0;
                  r_active   <= 1'b0;
                  r_silenced <= 1'b1;
               end else if (r_phase_cnt == c_OFF_LAST) begin
                  r_phase_cnt <= '0;
                  r_tone_cnt  <= '0;
                  // alarm_in only matters on this terminal cycle
                  if (alarm_in || (r_beep_count < c_MIN_BEEPS)) begin
                     r_state <= S_ON;
                     r_pwm   <= 1'b1;
                  end else begin
                     r_state  <= S_IDLE;
                     r_active <= 1'b0;
                  end
               end else begin
                  r_phase_cnt <= r_phase_cnt + c_PHASE_W'(1);
               end
            end

            S_SILENCED: begin
               if (!alarm_in) begin
                  r_state    <= S_IDLE;
                  r_silenced <= 1'b0;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_pwm      <= 1'b0;
               r_active   <= 1'b0;
               r_silenced <= 1'b0;
            end
         endcase
      end
   end

   assign buzzer_pwm = r_pwm;
   assign active     = r_active;
   assign silenced   = r_silenced;
   assign beep_count = r_beep_count;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_pattern_driver
//  Purpose  : Self-checking bench for buzzer_pattern_driver (small timing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_buzzer_pattern_driver;

   logic       clk = 1'b0;
   logic       reset, enable, alarm_in, silence;
   logic       buzzer_pwm, active, silenced;
   logic [7:0] beep_count;

   buzzer_pattern_driver #(
      .TONE_HALF (2),
      .BEEP_ON   (8),
      .BEEP_OFF  (4),
      .MIN_BEEPS (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .alarm_in   (alarm_in),
      .silence    (silence),
      .buzzer_pwm (buzzer_pwm),
      .active     (active),
      .silenced   (silenced),
      .beep_count (beep_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pwm;
      logic       act;
      logic       sil;
      logic [7:0] beep;
   } exp_t;

   typedef struct {
      logic rst;
      logic en;
      logic al;
      logic sl;
      exp_t ex;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[29];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic p, input logic a, input logic s, input int b);
      exp_t e;
      e.pwm = p; e.act = a; e.sil = s; e.beep = 8'(b);
      return e;
   endfunction

   // Expected outputs k edges after ON entry with the cadence uninterrupted
   function automatic exp_t cad(input int k);
      int p, b;
      p = k % 12;
      b = (k < 8) ? 0 : ((k - 8) / 12 + 1);
      if (b > 255) b = 255;
      return mk(((p < 8) && (((p / 2) % 2) == 0)), 1'b1, 1'b0, b);
   endfunction

   task automatic step(input logic r, input logic e, input logic a, input logic s,
                       input exp_t ex, input string name);
      exp_t got;
      reset = r; enable = e; alarm_in = a; silence = s;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         got = sb.pop_front();
         if ({buzzer_pwm, active, silenced, beep_count} !== {got.pwm, got.act, got.sil, got.beep}) begin
            errors++;
            $display("FAIL %s @%0t: got pwm=%0b active=%0b silenced=%0b beep=%0d, want pwm=%0b active=%0b silenced=%0b beep=%0d",
                     name, $time, buzzer_pwm, active, silenced, beep_count,
                     got.pwm, got.act, got.sil, got.beep);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; enable = 1'b1; alarm_in = 1'b0; silence = 1'b0;

      // Reset with alarm high, then a single-cycle alarm pulse through to IDLE
      for (int i = 0; i < 3; i++) begin
         vecs[i].rst = 1'b1; vecs[i].en = 1'b1; vecs[i].al = 1'b1; vecs[i].sl = 1'b0;
         vecs[i].ex  = mk(0, 0, 0, 0);
      end
      for (int k = 0; k < 24; k++) begin
         vecs[3+k].rst = 1'b0; vecs[3+k].en = 1'b1; vecs[3+k].al = (k == 0); vecs[3+k].sl = 1'b0;
         vecs[3+k].ex  = cad(k);
      end
      for (int i = 27; i < 29; i++) begin
         vecs[i].rst = 1'b0; vecs[i].en = 1'b1; vecs[i].al = 1'b0; vecs[i].sl = 1'b0;
         vecs[i].ex  = mk(0, 0, 0, 2);
      end

      for (int i = 0; i < 29; i++)
         step(vecs[i].rst, vecs[i].en, vecs[i].al, vecs[i].sl, vecs[i].ex,
              (i < 3) ? "reset_hold" : "pulse_cadence");

      // Alarm held: continuous cadence, beep_count saturates at 255
      for (int k = 0; k < 3100; k++)
         step(0, 1, 1, 0, cad(k), "long_cadence");
      step(0, 0, 0, 0, mk(0, 0, 0, 255), "disable_from_on");

      // Silence mid-ON, hold while alarm high, exit on alarm low, re-arm
      for (int k = 0; k < 3; k++)
         step(0, 1, 1, 0, cad(k), "sil_pre");
      step(0, 1, 1, 1, mk(0, 0, 1, 0), "sil_mid_on");
      step(0, 1, 1, 0, mk(0, 0, 1, 0), "sil_hold");
      step(0, 1, 1, 1, mk(0, 0, 1, 0), "sil_repeat_ignored");
      step(0, 1, 0, 0, mk(0, 0, 0, 0), "sil_exit");
      step(0, 1, 1, 0, cad(0), "sil_reentry");

      // enable low mid-OFF, alarm ignored while disabled
      for (int k = 1; k < 10; k++)
         step(0, 1, 0, 0, cad(k), "en_pre");
      step(0, 0, 0, 0, mk(0, 0, 0, 1), "en_off_mid_off");
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, mk(0, 0, 0, 1), "en_off_alarm_ignored");
      step(0, 1, 1, 0, cad(0), "rearm");

      // Silence coincident with ON terminal count: no increment
      for (int k = 1; k < 8; k++)
         step(0, 1, 0, 0, cad(k), "term_pre");
      step(0, 1, 0, 1, mk(0, 0, 1, 0), "sil_at_on_terminal");
      step(0, 1, 0, 0, mk(0, 0, 0, 0), "sil_exit2");
      step(0, 1, 0, 1, mk(0, 0, 0, 0), "sil_in_idle_ignored");

      // Reset mid-ON while pwm high
      step(0, 1, 1, 0, cad(0), "rst_pre0");
      step(0, 1, 1, 0, cad(1), "rst_pre1");
      step(1, 1, 1, 0, mk(0, 0, 0, 0), "rst_mid_on");
      step(0, 1, 0, 0, mk(0, 0, 0, 0), "post_rst_idle");
      step(0, 1, 0, 0, mk(0, 0, 0, 0), "post_rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
